msu_data_buffer: RTL and testbench

// - 16 KiB simple dual-port RAM holding the MSU-1 data stream window.
// - Port A (write) is filled by the MCU program/data loader; port B (read) feeds the SNES-side MSU data register ($2001 reads).
// - The MSU register block drives rdaddress from its auto-incrementing 14-bit pointer and samples q on a register-read strobe.
// - Single clock domain, synchronous RAM with a registered read port.

---
 rtl/msu_data_buffer.sv | 48 ++++
 tb/tb_msu_data_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/msu_data_buffer.sv
// msu_data_buffer
//   Simple dual-port RAM holding the MSU-1 data stream window.
//   Port A (write) is loaded by the MCU; port B (read) feeds the SNES-side
//   MSU data register. Single clock, registered read port (block RAM).
//
// Ports
//   clkin      in   1       system clock, rising edge
//   rst_n      in   1       async active-low reset, clears q only
//   wren       in   1       write enable, active high
//   wraddress  in   ADDR_W  write address
//   data       in   DATA_W  write data
//   rdaddress  in   ADDR_W  read address
//   q          out  DATA_W  registered read data (1-cycle latency)
module msu_data_buffer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Memory contents are deliberately not reset.
  always_ff @(posedge clkin) begin
    if (wren) begin
      mem[wraddress] <= data;
    end
  end

  // Read-first on a same-address collision: the non-blocking write above
  // lands after this edge's read samples the old word.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= mem[rdaddress];
    end
  end

endmodule

// File: tb/tb_msu_data_buffer.sv
module tb_msu_data_buffer;

  logic        clkin;
  logic        rst_n;
  logic        wren;
  logic [13:0] wraddress;
  logic [7:0]  data;
  logic [13:0] rdaddress;
  logic [7:0]  q;

  int checks;
  int errors;

  // Scoreboard: one entry per issued cycle, popped by the monitor after the
  // following rising edge.
  bit          sb_chk [$];
  logic [7:0]  sb_exp [$];
  string       sb_nm  [$];

  msu_data_buffer #(.ADDR_W(14), .DATA_W(8)) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .wren      (wren),
    .wraddress (wraddress),
    .data      (data),
    .rdaddress (rdaddress),
    .q         (q)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor
  always @(posedge clkin) begin
    #1;
    if (sb_chk.size() > 0) begin
      bit         c;
      logic [7:0] e;
      string      n;
      c = sb_chk.pop_front();
      e = sb_exp.pop_front();
      n = sb_nm.pop_front();
      if (c) begin
        checks++;
        if (q !== e) begin
          errors++;
          $display("FAIL %s: q=%02h required %02h", n, q, e);
        end
      end
    end
  end

  // Drive one cycle's inputs at the falling edge and queue what q must be
  // after the next rising edge.
  task automatic cyc(input logic we, input logic [13:0] wa, input logic [7:0] wd,
                     input logic [13:0] ra, input bit chk, input logic [7:0] exp,
                     input string nm);
    @(negedge clkin);
    wren      = we;
    wraddress = wa;
    data      = wd;
    rdaddress = ra;
    sb_chk.push_back(chk);
    sb_exp.push_back(exp);
    sb_nm.push_back(nm);
  endtask

  task automatic direct_check(input logic [7:0] exp, input string nm);
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s: q=%02h required %02h", nm, q, exp);
    end
  endtask

  initial begin
    logic [13:0] a;
    logic [7:0]  pat;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    wren      = 1'b0;
    wraddress = '0;
    data      = '0;
    rdaddress = '0;
    #3;
    direct_check(8'h00, "reset_initial");
    repeat (2) cyc(1'b0, 14'h0, 8'h0, 14'h0, 1'b1, 8'h00, "reset_hold");
    @(negedge clkin);
    rst_n = 1'b1;

    // Write/readback including the top location
    cyc(1'b1, 14'h0000, 8'h53, 14'h0000, 1'b0, 8'h00, "wr0");
    cyc(1'b1, 14'h0001, 8'h2D, 14'h0000, 1'b1, 8'h53, "rd0000_collide_diff");
    cyc(1'b1, 14'h3FFF, 8'h31, 14'h0001, 1'b1, 8'h2D, "rd0001");
    cyc(1'b0, 14'h0000, 8'h00, 14'h3FFF, 1'b1, 8'h31, "rd3FFF");
    cyc(1'b0, 14'h0000, 8'h00, 14'h0000, 1'b1, 8'h53, "rd0000");

    // Reset forces q to zero asynchronously, memory survives
    cyc(1'b1, 14'h0050, 8'hA5, 14'h0000, 1'b1, 8'h53, "wrA5");
    cyc(1'b0, 14'h0000, 8'h00, 14'h0050, 1'b1, 8'hA5, "rdA5");
    @(negedge clkin);
    #2;
    rst_n = 1'b0;
    #1;
    direct_check(8'h00, "async_reset");
    cyc(1'b0, 14'h0000, 8'h00, 14'h0050, 1'b1, 8'h00, "reset_mid_hold");
    cyc(1'b0, 14'h0000, 8'h00, 14'h0050, 1'b1, 8'h00, "reset_mid_hold");
    @(negedge clkin);
    rst_n = 1'b1;
    cyc(1'b0, 14'h0000, 8'h00, 14'h0050, 1'b1, 8'hA5, "rd_after_reset");

    // Streaming: fill then read back-to-back
    for (int unsigned i = 0; i < 256; i++) begin
      a = 14'h0100 + 14'(i);
      cyc(1'b1, a, a[7:0], 14'h0000, 1'b0, 8'h00, "fill");
    end
    for (int unsigned i = 0; i < 256; i++) begin
      a = 14'h0100 + 14'(i);
      cyc(1'b0, 14'h0000, 8'h00, a, 1'b1, 8'(i), "stream");
    end

    // Read-during-write is read-first
    cyc(1'b1, 14'h0010, 8'h11, 14'h0000, 1'b1, 8'h53, "wr11");
    cyc(1'b1, 14'h0010, 8'h22, 14'h0010, 1'b1, 8'h11, "rdw_old");
    cyc(1'b1, 14'h0030, 8'h12, 14'h0010, 1'b1, 8'h22, "rdw_new");
    cyc(1'b0, 14'h0000, 8'h00, 14'h0030, 1'b1, 8'h12, "indep_write");

    // wren=0 guard
    cyc(1'b1, 14'h0020, 8'h77, 14'h0000, 1'b1, 8'h53, "wr77");
    for (int unsigned i = 0; i < 10; i++)
      cyc(1'b0, 14'h0020, 8'hFF, 14'h0020, 1'b1, 8'h77, "wren0_guard");
    cyc(1'b0, 14'h0020, 8'hFF, 14'h0010, 1'b1, 8'h22, "wren0_other");

    // Full sweep
    for (int unsigned i = 0; i < 16384; i++) begin
      a   = 14'(i);
      pat = a[7:0] ^ a[13:6];
      cyc(1'b1, a, pat, 14'h0000, 1'b0, 8'h00, "sweep_wr");
    end
    for (int unsigned i = 0; i < 16384; i++) begin
      a   = 14'(i);
      pat = a[7:0] ^ a[13:6];
      cyc(1'b0, 14'h0000, 8'h00, a, 1'b1, pat, "sweep_rd");
    end

    @(negedge clkin);
    wren = 1'b0;
    repeat (2) @(negedge clkin);
    checks++;
    if (sb_chk.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required 0", sb_chk.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
